mvau_wmem_seq: RTL and testbench
================================

Name: mvau_wmem_seq

Overview:
- Address sequencer and control stage directly upstream of the MVAU weight memory.
- Walks the weight memory over SF synapse folds × NF neuron folds.
- Gates consumption of input-activation beats: input is consumed only on the first neuron fold and reused on later folds.
- Emits a valid/last tag aligned with the memory's 1-cycle registered read data for the downstream compute stage.

Parameters:
- SIMD, 2, input lanes per beat (carried for width consistency with the weight memory)
- TW, 1, weight bit width (carried for width consistency)
- SF, 2, synapse folds per output vector (MatrixW/SIMD); must be ≥1
- NF, 2, neuron folds per input vector (MatrixH/PE); must be ≥1
- WMEM_DEPTH, 4, must equal SF*NF
- WMEM_ADDR_BW, 4, weight memory address width; must be ≥ clog2(WMEM_DEPTH)

Ports:
- aclk  in  1  main clock, rising edge
- areset  in  1  asynchronous, active-high reset
- in_v  in  1  input activation beat valid
- in_rdy  out  1  input beat accepted this cycle when in_v && in_rdy
- out_rdy  in  1  downstream can accept one result beat two cycles later
- wmem_addr  out  WMEM_ADDR_BW  weight memory read address (registered)
- ibuf_addr  out  clog2(SF) (min 1)  input-buffer slot = current sf index
- ibuf_we  out  1  write accepted input beat into ibuf_addr (FILL only)
- wmem_vld  out  1  wmem_out valid this cycle
- sf_last  out  1  with wmem_vld: last synapse fold of this neuron fold
- nf_last  out  1  with wmem_vld: last neuron fold of this input vector

Behaviour:
- Reset (asynchronous assertion, synchronous release):
  - Outputs: wmem_addr=0, wmem_vld=0, sf_last=0, nf_last=0, in_rdy=0, ibuf_we=0, ibuf_addr=0.
  - Internal: sf_cnt=0, nf_cnt=0, state=FILL.
- FSM, two states:
  - FILL (nf_cnt==0): in_rdy=out_rdy. adv = in_v && out_rdy. ibuf_we = adv.
  - REUSE (nf_cnt>0): in_rdy=0. adv = out_rdy. ibuf_we = 0.
- On an adv cycle:
  - The memory samples the current wmem_addr at the edge.
  - At the same edge, wmem_addr increments. It wraps WMEM_DEPTH-1 → 0.
  - sf_cnt increments.
  - When sf_cnt==SF-1: sf_cnt←0 and nf_cnt increments.
  - When nf_cnt==NF-1 at that point: nf_cnt←0.
- State transitions:
  - FILL→REUSE: adv at sf_cnt==SF-1 with NF>1.
  - REUSE→FILL: adv at sf_cnt==SF-1, nf_cnt==NF-1.
  - NF==1: the FSM stays in FILL permanently.
- Address invariant: wmem_addr == nf_cnt*SF + sf_cnt at all times. No multiplier; wmem_addr is a separate wrapping counter.
- ibuf_addr = sf_cnt, combinational from the register.
- Output timing:
  - wmem_vld is adv registered once, so it coincides with wmem_out for that address.
  - sf_last and nf_last are registered together with wmem_vld and are 0 whenever wmem_vld=0.
- Stall:
  - No adv → all counters and wmem_addr hold.
  - The memory keeps re-reading the same address; this is harmless.
  - Exactly one wmem_vld pulse per address issued.
- Handshake: downstream must accept every wmem_vld beat. out_rdy must already account for in-flight beats.
- Simultaneous in_v with out_rdy=0 in FILL: no accept, no advance.
- Reset mid-vector: the partial vector is discarded. Restart at FILL with wmem_addr=0; no wmem_vld is emitted for the partial vector.

Optional Feature:
- Macro: MVAU_WMEM_SEQ_PERF_EN.
- Defined: adds output stall_cnt [31:0], reset 0. It increments (saturating at 2^32-1) every cycle in which the sequencer is stalled:
  - FILL && !(in_v && out_rdy), or
  - REUSE && !out_rdy.
- Undefined: the port and its logic are absent.

Decomposition:
- Package mvau_pkg holds:
  - typedef enum logic {FILL, REUSE} wseq_state_t
  - function clog2_min1 for the ibuf_addr width
- Sub-module mvau_fold_cnt, instantiated twice (sf, nf):
  - Parameterised MAX.
  - Inputs inc; outputs cnt and last (cnt==MAX-1).
  - Wraps to 0 on inc when last.

Test Plan:
- Continuous flow:
  - Stimulus: SF=2, NF=2, in_v=1, out_rdy=1 from reset.
  - Required response:
    - wmem_addr sequence 0,1,2,3,0,…
    - in_rdy high only while addr 0,1 are issued.
    - wmem_vld high one cycle after each issue.
    - sf_last on beats 2 and 4; nf_last on beats 3 and 4.
- Input starvation:
  - Stimulus: in_v low for 3 cycles during FILL at sf_cnt=1.
  - Required response: wmem_addr holds at 1; no wmem_vld; with the macro, stall_cnt=3.
- Back-pressure in REUSE:
  - Stimulus: out_rdy=0 for 2 cycles at addr 2.
  - Required response: addr holds at 2; in_rdy=0 throughout; resumes 2,3 after out_rdy returns.
- NF=1 configuration:
  - Stimulus: SF=3, NF=1, continuous input.
  - Required response: in_rdy constantly equals out_rdy; addresses 0,1,2,0; nf_last set on every beat.
- Reset mid-vector:
  - Stimulus: assert areset asynchronously at addr 3 (REUSE).
  - Required response: all outputs go to 0 immediately. After release, the first issued address is 0 in FILL with in_rdy=out_rdy.
- Input-buffer write:
  - Stimulus: in_v pulses with out_rdy=1.
  - Required response: ibuf_we pulses only on accepted beats, with ibuf_addr=0 then 1; no ibuf_we during REUSE.

Source files
------------

// File: rtl/mvau_pkg.sv
// Shared types and helpers for the MVAU weight-memory address sequencer.
package mvau_pkg;

    typedef enum logic {
        FILL  = 1'b0,
        REUSE = 1'b1
    } wseq_state_t;

    // Width of an index into n slots; never below 1 bit so single-slot configs still elaborate.
    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/mvau_fold_cnt.sv
// Wrapping fold counter: counts 0..MAX-1 on inc, flags the final fold.
module mvau_fold_cnt
    import mvau_pkg::*;
#(
    parameter int MAX = 2,
    localparam int W = clog2_min1(MAX)
) (
    input  logic         aclk,
    input  logic         areset,
    input  logic         inc,
    output logic [W-1:0] cnt,
    output logic         last
);

    logic [W-1:0] cnt_reg;

    assign cnt  = cnt_reg;
    assign last = (cnt_reg == W'(MAX - 1));

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            cnt_reg <= '0;
        end else if (inc) begin
            cnt_reg <= last ? '0 : cnt_reg + W'(1);
        end
    end

endmodule

// File: rtl/mvau_wmem_seq.sv
// Weight-memory address sequencer: walks SF x NF folds, gates input beats to the first neuron fold.
// Optional MVAU_WMEM_SEQ_PERF_EN adds a saturating stall_cnt output.
module mvau_wmem_seq
    import mvau_pkg::*;
#(
    parameter int SIMD         = 2,
    parameter int TW           = 1,
    parameter int SF           = 2,
    parameter int NF           = 2,
    parameter int WMEM_DEPTH   = 4,
    parameter int WMEM_ADDR_BW = 4,
    localparam int IBUF_BW     = clog2_min1(SF)
) (
    input  logic                    aclk,
    input  logic                    areset,
    input  logic                    in_v,
    output logic                    in_rdy,
    input  logic                    out_rdy,
    output logic [WMEM_ADDR_BW-1:0] wmem_addr,
    output logic [IBUF_BW-1:0]      ibuf_addr,
    output logic                    ibuf_we,
    output logic                    wmem_vld,
    output logic                    sf_last,
    output logic                    nf_last
`ifdef MVAU_WMEM_SEQ_PERF_EN
    ,
    output logic [31:0]             stall_cnt
`endif
);

    localparam int  NF_BW    = clog2_min1(NF);
    localparam bit  MULTI_NF = (NF > 1);

    if (SF < 1 || NF < 1 || SIMD < 1 || TW < 1 || WMEM_DEPTH != SF * NF ||
        WMEM_ADDR_BW < clog2_min1(WMEM_DEPTH)) begin : g_bad_cfg
        $error("mvau_wmem_seq: inconsistent fold/depth parameters");
    end

    wseq_state_t             state_reg;
    wseq_state_t             state_next;
    logic                    adv;
    logic                    in_rdy_c;
    logic                    ibuf_we_c;
    logic [IBUF_BW-1:0]      sf_cnt;
    logic                    sf_at_last;
    logic [NF_BW-1:0]        nf_cnt_unused;
    logic                    nf_at_last;
    logic [WMEM_ADDR_BW-1:0] wmem_addr_reg;
    logic                    wmem_vld_reg;
    logic                    sf_last_reg;
    logic                    nf_last_reg;

    mvau_fold_cnt #(.MAX(SF)) u_sf_cnt (
        .aclk   (aclk),
        .areset (areset),
        .inc    (adv),
        .cnt    (sf_cnt),
        .last   (sf_at_last)
    );

    mvau_fold_cnt #(.MAX(NF)) u_nf_cnt (
        .aclk   (aclk),
        .areset (areset),
        .inc    (adv && sf_at_last),
        .cnt    (nf_cnt_unused),
        .last   (nf_at_last)
    );

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state_reg <= FILL;
        end else begin
            state_reg <= state_next;
        end
    end

    // Handshake is masked while reset is held so no beat is taken from a sequencer that is not running.
    always_comb begin
        state_next = state_reg;
        adv        = 1'b0;
        in_rdy_c   = 1'b0;
        ibuf_we_c  = 1'b0;
        case (state_reg)
            FILL: begin
                in_rdy_c  = out_rdy && !areset;
                adv       = in_v && in_rdy_c;
                ibuf_we_c = adv;
                if (adv && sf_at_last && MULTI_NF) begin
                    state_next = REUSE;
                end
            end
            REUSE: begin
                adv = out_rdy && !areset;
                if (adv && sf_at_last && nf_at_last) begin
                    state_next = FILL;
                end
            end
            default: state_next = FILL;
        endcase
    end

    // Address runs as its own wrapping counter so it stays equal to nf*SF + sf without a multiplier.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            wmem_addr_reg <= '0;
            wmem_vld_reg  <= 1'b0;
            sf_last_reg   <= 1'b0;
            nf_last_reg   <= 1'b0;
        end else begin
            if (adv) begin
                wmem_addr_reg <= (wmem_addr_reg == WMEM_ADDR_BW'(WMEM_DEPTH - 1)) ?
                                 '0 : wmem_addr_reg + WMEM_ADDR_BW'(1);
            end
            wmem_vld_reg <= adv;
            sf_last_reg  <= adv && sf_at_last;
            nf_last_reg  <= adv && nf_at_last;
        end
    end

    assign in_rdy    = in_rdy_c;
    assign ibuf_we   = ibuf_we_c;
    assign ibuf_addr = sf_cnt;
    assign wmem_addr = wmem_addr_reg;
    assign wmem_vld  = wmem_vld_reg;
    assign sf_last   = sf_last_reg;
    assign nf_last   = nf_last_reg;

`ifdef MVAU_WMEM_SEQ_PERF_EN
    logic [31:0] stall_cnt_reg;

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            stall_cnt_reg <= '0;
        end else if (!adv && stall_cnt_reg != '1) begin
            stall_cnt_reg <= stall_cnt_reg + 32'd1;
        end
    end

    assign stall_cnt = stall_cnt_reg;
`endif

endmodule

// File: tb/tb_mvau_wmem_seq.sv
// Bench for mvau_wmem_seq: directed vector table, reset corner case, random traffic vs a fold-index model.
module tb_mvau_wmem_seq;

    localparam int SF     = 2;
    localparam int NF     = 2;
    localparam int DEPTH  = SF * NF;
    localparam int SF1    = 3;
    localparam int DEPTH1 = SF1;

    logic       aclk = 1'b0;
    logic       areset = 1'b1;

    logic       in_v, out_rdy, in_rdy, ibuf_we, wmem_vld, sf_last, nf_last;
    logic [3:0] wmem_addr;
    logic [0:0] ibuf_addr;

    logic       in_v_1, out_rdy_1, in_rdy_1, ibuf_we_1, wmem_vld_1, sf_last_1, nf_last_1;
    logic [1:0] wmem_addr_1;
    logic [1:0] ibuf_addr_1;

`ifdef MVAU_WMEM_SEQ_PERF_EN
    logic [31:0] stall_cnt, stall_cnt_1;
`endif

    always #5 aclk = ~aclk;

    mvau_wmem_seq #(.SIMD(2), .TW(1), .SF(SF), .NF(NF), .WMEM_DEPTH(DEPTH), .WMEM_ADDR_BW(4)) u_dut (
        .aclk(aclk), .areset(areset), .in_v(in_v), .in_rdy(in_rdy), .out_rdy(out_rdy),
        .wmem_addr(wmem_addr), .ibuf_addr(ibuf_addr), .ibuf_we(ibuf_we),
        .wmem_vld(wmem_vld), .sf_last(sf_last), .nf_last(nf_last)
`ifdef MVAU_WMEM_SEQ_PERF_EN
        , .stall_cnt(stall_cnt)
`endif
    );

    mvau_wmem_seq #(.SIMD(2), .TW(1), .SF(SF1), .NF(1), .WMEM_DEPTH(DEPTH1), .WMEM_ADDR_BW(2)) u_dut_nf1 (
        .aclk(aclk), .areset(areset), .in_v(in_v_1), .in_rdy(in_rdy_1), .out_rdy(out_rdy_1),
        .wmem_addr(wmem_addr_1), .ibuf_addr(ibuf_addr_1), .ibuf_we(ibuf_we_1),
        .wmem_vld(wmem_vld_1), .sf_last(sf_last_1), .nf_last(nf_last_1)
`ifdef MVAU_WMEM_SEQ_PERF_EN
        , .stall_cnt(stall_cnt_1)
`endif
    );

    int   n_cmp = 0;
    int   n_bad = 0;
    int   k     = 0;   // issued beats modulo DEPTH
    int   k1    = 0;
    int   m_stall  = 0;
    int   m_stall1 = 0;
    logic pre_in_rdy, pre_we;

    typedef struct {
        logic in_v;
        logic out_rdy;
        logic in_rdy;
        logic we;
        int   addr;
        logic vld;
        logic sfl;
        logic nfl;
    } vec_t;

    vec_t tbl[16];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, required %0d", name, act, exp);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_addr"},  32'(wmem_addr), 0);
        chk({tag, "_vld"},   32'(wmem_vld),  0);
        chk({tag, "_sfl"},   32'(sf_last),   0);
        chk({tag, "_nfl"},   32'(nf_last),   0);
        chk({tag, "_inrdy"}, 32'(in_rdy),    0);
        chk({tag, "_we"},    32'(ibuf_we),   0);
        chk({tag, "_ibuf"},  32'(ibuf_addr), 0);
    endtask

    // One clock of the SF=2/NF=2 instance, checked against fold indices derived from k.
    task automatic cycle(input logic vin, input logic ordy);
        int   sf, nf;
        logic fill, adv;
        @(negedge aclk);
        in_v = vin;
        out_rdy = ordy;
        #1;
        sf   = k % SF;
        nf   = k / SF;
        fill = (nf == 0);
        adv  = fill ? (vin && ordy) : ordy;
        pre_in_rdy = in_rdy;
        pre_we     = ibuf_we;
        chk("in_rdy",    32'(in_rdy),    32'(fill && ordy));
        chk("ibuf_we",   32'(ibuf_we),   32'(fill && adv));
        chk("ibuf_addr", 32'(ibuf_addr), sf);
        chk("addr_hold", 32'(wmem_addr), k);
        @(posedge aclk);
        #1;
        if (adv) k = (k + 1) % DEPTH;
        else     m_stall++;
        chk("wmem_addr", 32'(wmem_addr), k);
        chk("wmem_vld",  32'(wmem_vld),  32'(adv));
        chk("sf_last",   32'(sf_last),   32'(adv && sf == SF - 1));
        chk("nf_last",   32'(nf_last),   32'(adv && nf == NF - 1));
`ifdef MVAU_WMEM_SEQ_PERF_EN
        chk("stall_cnt", stall_cnt, m_stall);
`endif
        if (wmem_vld)
            $display("beat  nf2 next_addr=%0d sf_last=%0b nf_last=%0b", wmem_addr, sf_last, nf_last);
    endtask

    task automatic cycle1(input logic vin, input logic ordy);
        logic adv;
        int   sf;
        @(negedge aclk);
        in_v_1 = vin;
        out_rdy_1 = ordy;
        #1;
        sf  = k1;
        adv = vin && ordy;
        chk("nf1_in_rdy",    32'(in_rdy_1),    32'(ordy));
        chk("nf1_ibuf_we",   32'(ibuf_we_1),   32'(adv));
        chk("nf1_ibuf_addr", 32'(ibuf_addr_1), sf);
        @(posedge aclk);
        #1;
        if (adv) k1 = (k1 + 1) % DEPTH1;
        else     m_stall1++;
        chk("nf1_addr",    32'(wmem_addr_1), k1);
        chk("nf1_vld",     32'(wmem_vld_1),  32'(adv));
        chk("nf1_sf_last", 32'(sf_last_1),   32'(adv && sf == SF1 - 1));
        chk("nf1_nf_last", 32'(nf_last_1),   32'(adv));
`ifdef MVAU_WMEM_SEQ_PERF_EN
        chk("nf1_stall_cnt", stall_cnt_1, m_stall1);
`endif
        if (wmem_vld_1)
            $display("beat  nf1 next_addr=%0d sf_last=%0b nf_last=%0b", wmem_addr_1, sf_last_1, nf_last_1);
    endtask

    initial begin
        // in_v, out_rdy, in_rdy, ibuf_we, addr after edge, vld, sf_last, nf_last
        tbl[0]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1, 1'b1, 1'b0, 1'b0};
        tbl[1]  = '{1'b1, 1'b1, 1'b1, 1'b1, 2, 1'b1, 1'b1, 1'b0};
        tbl[2]  = '{1'b1, 1'b1, 1'b0, 1'b0, 3, 1'b1, 1'b0, 1'b1};
        tbl[3]  = '{1'b1, 1'b1, 1'b0, 1'b0, 0, 1'b1, 1'b1, 1'b1};
        tbl[4]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1, 1'b1, 1'b0, 1'b0};
        tbl[5]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1, 1'b0, 1'b0, 1'b0};
        tbl[6]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1, 1'b0, 1'b0, 1'b0};
        tbl[7]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1, 1'b0, 1'b0, 1'b0};
        tbl[8]  = '{1'b1, 1'b1, 1'b1, 1'b1, 2, 1'b1, 1'b1, 1'b0};
        tbl[9]  = '{1'b1, 1'b0, 1'b0, 1'b0, 2, 1'b0, 1'b0, 1'b0};
        tbl[10] = '{1'b1, 1'b0, 1'b0, 1'b0, 2, 1'b0, 1'b0, 1'b0};
        tbl[11] = '{1'b1, 1'b1, 1'b0, 1'b0, 3, 1'b1, 1'b0, 1'b1};
        tbl[12] = '{1'b1, 1'b1, 1'b0, 1'b0, 0, 1'b1, 1'b1, 1'b1};
        tbl[13] = '{1'b1, 1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0};
        tbl[14] = '{1'b0, 1'b1, 1'b1, 1'b0, 0, 1'b0, 1'b0, 1'b0};
        tbl[15] = '{1'b1, 1'b1, 1'b1, 1'b1, 1, 1'b1, 1'b0, 1'b0};

        in_v = 1'b1;
        out_rdy = 1'b1;
        in_v_1 = 1'b0;
        out_rdy_1 = 1'b0;

        // Held in reset with a live handshake offered: everything must stay quiet.
        repeat (2) @(posedge aclk);
        #1;
        chk_zero("rst");
        #1 areset = 1'b0;

        for (int i = 0; i < 16; i++) begin
            cycle(tbl[i].in_v, tbl[i].out_rdy);
            chk($sformatf("tbl%0d_in_rdy", i), 32'(pre_in_rdy), 32'(tbl[i].in_rdy));
            chk($sformatf("tbl%0d_we", i),     32'(pre_we),     32'(tbl[i].we));
            chk($sformatf("tbl%0d_addr", i),   32'(wmem_addr),  tbl[i].addr);
            chk($sformatf("tbl%0d_vld", i),    32'(wmem_vld),   32'(tbl[i].vld));
            chk($sformatf("tbl%0d_sfl", i),    32'(sf_last),    32'(tbl[i].sfl));
            chk($sformatf("tbl%0d_nfl", i),    32'(nf_last),    32'(tbl[i].nfl));
`ifdef MVAU_WMEM_SEQ_PERF_EN
            if (i == 7) chk("starve_stall_cnt", stall_cnt, 3);
`endif
        end

        // Advance to address 3 (REUSE), then hit reset asynchronously mid-cycle.
        for (int n = 0; n < 20 && k != 3; n++) cycle(1'b1, 1'b1);
        chk("reach_addr3", 32'(wmem_addr), 3);
        @(negedge aclk);
        #2 areset = 1'b1;
        #1;
        chk_zero("async_rst");
        k = 0;
        m_stall = 0;
        @(posedge aclk);
        #1;
        chk_zero("rst_edge");
        #1 areset = 1'b0;
        cycle(1'b1, 1'b1);
        chk("post_rst_in_rdy", 32'(pre_in_rdy), 1);
        chk("post_rst_addr",   32'(wmem_addr),  1);

        for (int n = 0; n < 300; n++)
            cycle(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) != 0));

        // NF=1 instance from a fresh reset: continuous, then random traffic.
        @(negedge aclk);
        in_v = 1'b0;
        out_rdy = 1'b0;
        areset = 1'b1;
        @(posedge aclk);
        #2 areset = 1'b0;
        k = 0;
        k1 = 0;
        m_stall = 0;
        m_stall1 = 0;
        for (int n = 0; n < 4; n++) cycle1(1'b1, 1'b1);
        chk("nf1_wrap_addr", 32'(wmem_addr_1), 1);
        for (int n = 0; n < 60; n++)
            cycle1(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) != 0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
